// File: rtl/sram_arb_pkg.sv
// Shared defaults and the slot-owner encoding for the SRAM port arbiter.
package sram_arb_pkg;

  localparam int unsigned STARVE_LIMIT_DEF = 16;
  localparam int unsigned CW_DEF           = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PORT_A = 2'd1,
    PORT_B = 2'd2
  } slot_owner_e;

endpackage

// File: rtl/sram_arb_starve_mon.sv
// Port B wait tracker: saturating wait counter, worst-case wait and a
// sticky flag raised when a request has waited STARVE_LIMIT cycles.
module sram_arb_starve_mon
  import sram_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int unsigned CW           = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic          gnt,
  input  logic          clr,
  output logic [CW-1:0] wait_cnt_o,
  output logic [CW-1:0] max_wait_o,
  output logic          starved_o
);

  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [CW-1:0] STARVE_AT = CW'(STARVE_LIMIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] max_q, max_d;
  logic          starved_q, starved_d;
  logic          starve_set;

  always_comb begin
    cnt_d = cnt_q;
    if (gnt) begin
      cnt_d = '0;
    end else if (req && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end

    max_d = max_q;
    if (clr) begin
      max_d = '0;
    end else if (gnt && (cnt_q > max_q)) begin
      max_d = cnt_q;
    end

    // A fresh starvation event must not be lost to a simultaneous clear.
    starve_set = req & ~gnt & (cnt_q == STARVE_AT);
    starved_d  = starve_set | (starved_q & ~clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      max_q     <= '0;
      starved_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      max_q     <= max_d;
      starved_q <= starved_d;
    end
  end

  assign wait_cnt_o = cnt_q;
  assign max_wait_o = max_q;
  assign starved_o  = starved_q;

endmodule

// File: rtl/sram_port_arbiter.sv
// Single-port SRAM sharing: AHB port A passes straight through with priority,
// port B fills idle slots via req/gnt and gets read data one cycle later.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned AW           = 14,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int unsigned CW           = CW_DEF
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          a_cs,
  input  logic [3:0]    a_wen,
  input  logic [AW-3:0] a_addr,
  input  logic [31:0]   a_wdata,
  output logic [31:0]   a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [3:0]    b_be,
  input  logic [AW-3:0] b_addr,
  input  logic [31:0]   b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [31:0]   b_rdata,
  output logic          SRAMCS,
  output logic [3:0]    SRAMWEN,
  output logic [AW-3:0] SRAMADDR,
  output logic [31:0]   SRAMWDATA,
  input  logic [31:0]   SRAMRDATA,
  input  logic          stat_clr,
  output logic [CW-1:0] b_wait_cnt,
  output logic [CW-1:0] b_max_wait,
  output logic          b_starved
);

  slot_owner_e slot_owner;
  logic        rd_pend_q, rd_pend_d;
  logic [31:0] hold_q, hold_d;

  assign b_gnt = b_req & ~a_cs & HRESETn;

  always_comb begin
    slot_owner = IDLE;
    if (a_cs) begin
      slot_owner = PORT_A;
    end else if (b_gnt) begin
      slot_owner = PORT_B;
    end
  end

  // Address/data default to port A so the A path stays a plain wire.
  always_comb begin
    SRAMCS    = 1'b0;
    SRAMWEN   = 4'b0000;
    SRAMADDR  = a_addr;
    SRAMWDATA = a_wdata;
    case (slot_owner)
      PORT_A: begin
        SRAMCS  = a_cs;
        SRAMWEN = a_wen;
      end
      PORT_B: begin
        SRAMCS    = 1'b1;
        SRAMWEN   = b_we ? b_be : 4'b0000;
        SRAMADDR  = b_addr;
        SRAMWDATA = b_wdata;
      end
      default: ;
    endcase
  end

  // A never reads in the cycle after a B slot, so the raw macro output serves it.
  assign a_rdata = SRAMRDATA;

  always_comb begin
    rd_pend_d = b_gnt & ~b_we;
    hold_d    = rd_pend_q ? SRAMRDATA : hold_q;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rd_pend_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      rd_pend_q <= rd_pend_d;
      hold_q    <= hold_d;
    end
  end

  assign b_rvalid = rd_pend_q;
  assign b_rdata  = rd_pend_q ? SRAMRDATA : hold_q;

  sram_arb_starve_mon #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .CW          (CW)
  ) u_starve_mon (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .req       (b_req),
    .gnt       (b_gnt),
    .clr       (stat_clr),
    .wait_cnt_o(b_wait_cnt),
    .max_wait_o(b_max_wait),
    .starved_o (b_starved)
  );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural synchronous SRAM.
module tb_sram_port_arbiter;

  localparam int AW = 14;
  localparam int CW = 8;

  logic          HCLK;
  logic          HRESETn;
  logic          a_cs;
  logic [3:0]    a_wen;
  logic [AW-3:0] a_addr;
  logic [31:0]   a_wdata;
  logic [31:0]   a_rdata;
  logic          b_req;
  logic          b_we;
  logic [3:0]    b_be;
  logic [AW-3:0] b_addr;
  logic [31:0]   b_wdata;
  logic          b_gnt;
  logic          b_rvalid;
  logic [31:0]   b_rdata;
  logic          SRAMCS;
  logic [3:0]    SRAMWEN;
  logic [AW-3:0] SRAMADDR;
  logic [31:0]   SRAMWDATA;
  logic [31:0]   SRAMRDATA;
  logic          stat_clr;
  logic [CW-1:0] b_wait_cnt;
  logic [CW-1:0] b_max_wait;
  logic          b_starved;

  int nvec = 0;
  int nerr = 0;

  logic [31:0] mem [0:(1<<(AW-2))-1];

  sram_port_arbiter #(.AW(AW), .STARVE_LIMIT(16), .CW(CW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .a_cs(a_cs), .a_wen(a_wen), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .SRAMCS(SRAMCS), .SRAMWEN(SRAMWEN), .SRAMADDR(SRAMADDR), .SRAMWDATA(SRAMWDATA),
    .SRAMRDATA(SRAMRDATA), .stat_clr(stat_clr),
    .b_wait_cnt(b_wait_cnt), .b_max_wait(b_max_wait), .b_starved(b_starved)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  initial begin
    for (int w = 0; w < (1<<(AW-2)); w++) mem[w] = 32'h0;
    SRAMRDATA = 32'h0;
  end

  always @(posedge HCLK) begin
    if (SRAMCS) begin
      if (SRAMWEN != 4'b0000) begin
        for (int k = 0; k < 4; k++)
          if (SRAMWEN[k]) mem[SRAMADDR][8*k +: 8] <= SRAMWDATA[8*k +: 8];
      end else begin
        SRAMRDATA <= mem[SRAMADDR];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    HRESETn = 1'b0; stat_clr = 1'b0;
    a_cs = 1'b0; a_wen = 4'h0; a_addr = '0; a_wdata = 32'h0;
    b_req = 1'b1; b_we = 1'b0; b_be = 4'h0; b_addr = '0; b_wdata = 32'h0;
    #3;
    check("rst_gnt",     {31'h0, b_gnt},     32'h0);
    check("rst_rvalid",  {31'h0, b_rvalid},  32'h0);
    check("rst_rdata",   b_rdata,            32'h0);
    check("rst_cs",      {31'h0, SRAMCS},    32'h0);
    step();
    check("rst_waitcnt", {24'h0, b_wait_cnt}, 32'h0);
    check("rst_maxwait", {24'h0, b_max_wait}, 32'h0);
    check("rst_starved", {31'h0, b_starved},  32'h0);
    b_req = 1'b0; HRESETn = 1'b1;
    step();

    // B write with A idle
    b_req = 1'b1; b_we = 1'b1; b_addr = 12'h010; b_wdata = 32'hDEADBEEF; b_be = 4'hF;
    #1;
    check("wr_gnt",  {31'h0, b_gnt},   32'h1);
    check("wr_cs",   {31'h0, SRAMCS},  32'h1);
    check("wr_wen",  {28'h0, SRAMWEN}, 32'hF);
    check("wr_addr", {20'h0, SRAMADDR}, 32'h010);
    check("wr_data", SRAMWDATA,        32'hDEADBEEF);
    step();

    // B read back-to-back
    b_we = 1'b0; b_wdata = 32'h0;
    #1;
    check("rd_gnt", {31'h0, b_gnt},   32'h1);
    check("rd_wen", {28'h0, SRAMWEN}, 32'h0);
    step();
    b_req = 1'b0;
    check("rd_rvalid", {31'h0, b_rvalid}, 32'h1);
    check("rd_rdata",  b_rdata,           32'hDEADBEEF);
    step();
    check("rd_rvalid_off", {31'h0, b_rvalid}, 32'h0);
    check("rd_hold",       b_rdata,           32'hDEADBEEF);

    // Collision: A read at 0x020 vs B write at 0x030
    a_cs = 1'b1; a_wen = 4'h0; a_addr = 12'h020;
    b_req = 1'b1; b_we = 1'b1; b_addr = 12'h030; b_wdata = 32'h12345678; b_be = 4'hF;
    #1;
    check("col_gnt",  {31'h0, b_gnt},   32'h0);
    check("col_addr", {20'h0, SRAMADDR}, 32'h020);
    check("col_wen",  {28'h0, SRAMWEN}, 32'h0);
    step();
    a_cs = 1'b0;
    #1;
    check("col_cnt1",  {24'h0, b_wait_cnt}, 32'h1);
    check("col_gnt2",  {31'h0, b_gnt},      32'h1);
    check("col_addr2", {20'h0, SRAMADDR},   32'h030);
    step();
    b_req = 1'b0;
    check("col_max",  {24'h0, b_max_wait}, 32'h1);
    check("col_cnt0", {24'h0, b_wait_cnt}, 32'h0);

    // Byte-lane write, then A reads the word back
    b_req = 1'b1; b_we = 1'b1; b_be = 4'b0010; b_wdata = 32'h0000AB00; b_addr = 12'h030;
    #1;
    check("bl_wen", {28'h0, SRAMWEN}, 32'h2);
    step();
    b_req = 1'b0; a_cs = 1'b1; a_wen = 4'h0; a_addr = 12'h030;
    #1;
    check("bl_a_cs",   {31'h0, SRAMCS},   32'h1);
    check("bl_a_addr", {20'h0, SRAMADDR}, 32'h030);
    step();
    a_cs = 1'b0;
    check("bl_a_rdata", a_rdata, 32'h1234AB78);

    // Clear stats before starvation run
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    check("clr_max", {24'h0, b_max_wait}, 32'h0);

    // Starvation: A busy for 20 cycles
    a_cs = 1'b1; a_addr = 12'h040;
    b_req = 1'b1; b_we = 1'b1; b_be = 4'hF; b_addr = 12'h050; b_wdata = 32'h55AA55AA;
    for (int i = 1; i <= 20; i++) begin
      step();
      check($sformatf("stv_cnt%0d", i), {24'h0, b_wait_cnt}, i);
      check($sformatf("stv_flag%0d", i), {31'h0, b_starved}, (i >= 16) ? 32'h1 : 32'h0);
    end
    a_cs = 1'b0;
    #1;
    check("stv_gnt", {31'h0, b_gnt}, 32'h1);
    step();
    b_req = 1'b0;
    check("stv_max",  {24'h0, b_max_wait}, 32'd20);
    check("stv_cnt0", {24'h0, b_wait_cnt}, 32'h0);
    check("stv_keep", {31'h0, b_starved},  32'h1);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    check("stv_clr_flag", {31'h0, b_starved},  32'h0);
    check("stv_clr_max",  {24'h0, b_max_wait}, 32'h0);

    // Counter saturation
    a_cs = 1'b1; b_req = 1'b1;
    for (int i = 0; i < 300; i++) step();
    check("sat_cnt", {24'h0, b_wait_cnt}, 32'd255);
    a_cs = 1'b0;
    step();
    b_req = 1'b0;
    check("sat_max", {24'h0, b_max_wait}, 32'd255);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;

    // Reset while a B read is pending
    a_cs = 1'b1; b_req = 1'b1; b_we = 1'b0; b_addr = 12'h010;
    step();
    a_cs = 1'b0;
    step();
    b_req = 1'b0;
    check("mr_rvalid_pre", {31'h0, b_rvalid}, 32'h1);
    check("mr_max_pre",    {24'h0, b_max_wait}, 32'h1);
    HRESETn = 1'b0;
    #1;
    check("mr_rvalid", {31'h0, b_rvalid},    32'h0);
    check("mr_rdata",  b_rdata,              32'h0);
    check("mr_cnt",    {24'h0, b_wait_cnt},  32'h0);
    check("mr_max",    {24'h0, b_max_wait},  32'h0);
    step();
    HRESETn = 1'b1;
    step();
    check("mr_rvalid_post", {31'h0, b_rvalid}, 32'h0);
    check("mr_rdata_post",  b_rdata,           32'h0);
    check("mr_starved",     {31'h0, b_starved}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
